fetch_queue: RTL and testbench

Parametrised successor to the single-instruction fetch FSM: a prefetching instruction fetch unit that keeps up to `QUEUE_DEPTH` sequential instructions buffered ahead of the decoder. It sits between the instruction-side memory port (cache) and the decoder. It issues one outstanding read at a time and advances its own PC by 4 per fetch. A registered redirect input, driven by branch/jump resolution, flushes the queue and squashes any in-flight read.

---
 rtl/fetch_queue.sv | 165 ++++++++++++++++
 tb/tb_fetch_queue.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: prefetching instruction fetch unit. Keeps up to QUEUE_DEPTH sequential
// instructions buffered ahead of the decoder, with one outstanding memory read at a time.
// A redirect flushes the queue and squashes any in-flight read. A read squashed before
// its response is drained: its address stays on the bus until the response arrives.
// Optional feature: define FETCH_BYPASS_EN to present a response straight to the decoder
// when the queue is empty.
module fetch_queue #(
    parameter int unsigned QUEUE_DEPTH = 4,
    parameter logic [31:0] RESET_PC    = 32'h0000_0060
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               redirect_i,
    input  logic [31:0]                        redirect_pc_i,
    output logic [31:0]                        mem_address_o,
    output logic                               mem_read_o,
    input  logic [31:0]                        mem_rdata_i,
    input  logic                               mem_resp_i,
    output logic                               instr_valid_o,
    input  logic                               instr_ready_i,
    output logic [31:0]                        instr_o,
    output logic [31:0]                        instr_pc_o,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(QUEUE_DEPTH);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDrain
    } state_e;

    state_e        state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   squash_pc_q, squash_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   instr_mem_q [QUEUE_DEPTH];
    logic [31:0]   pc_mem_q    [QUEUE_DEPTH];

    logic          resp_ok;
    logic          bypass;
    logic          enq;
    logic          deq;
    logic [CW-1:0] count_after;

    // Handshake decode: which response is kept, and what moves in and out of the queue.
    always_comb begin
        resp_ok = (state_q == StReq) & mem_resp_i & ~redirect_i;
`ifdef FETCH_BYPASS_EN
        bypass  = resp_ok & (count_q == '0);
`else
        bypass  = 1'b0;
`endif
        deq     = (count_q != '0) & ~redirect_i & instr_ready_i;
        // A bypassed word that the decoder takes is never written into the queue.
        enq     = resp_ok & ~(bypass & instr_ready_i);

        count_after = count_q;
        if (enq && !deq) begin
            count_after = count_q + CW'(1);
        end else if (!enq && deq) begin
            count_after = count_q - CW'(1);
        end
    end

    // Output decode from registered state plus the optional bypass path.
    always_comb begin
        mem_read_o    = (state_q == StReq) | (state_q == StDrain);
        mem_address_o = (state_q == StDrain) ? squash_pc_q : fetch_pc_q;
        instr_valid_o = ((count_q != '0) | bypass) & ~redirect_i;
        instr_o       = bypass ? mem_rdata_i : instr_mem_q[rd_ptr_q];
        instr_pc_o    = bypass ? fetch_pc_q : pc_mem_q[rd_ptr_q];
        count_o       = count_q;
    end

    // Next-state logic: redirect overrides everything, else normal fetch/queue flow.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        squash_pc_d = squash_pc_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        if (redirect_i) begin
            fetch_pc_d = redirect_pc_i;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            count_d    = '0;
            if ((state_q == StReq) && !mem_resp_i) begin
                // Keep the squashed address on the bus until its response returns.
                state_d     = StDrain;
                squash_pc_d = fetch_pc_q;
            end else if ((state_q == StDrain) && !mem_resp_i) begin
                state_d = StDrain;
            end else begin
                state_d = StIdle;
            end
        end else begin
            count_d = count_after;
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            case (state_q)
                StIdle: begin
                    if (count_q < CW'(QUEUE_DEPTH)) begin
                        state_d = StReq;
                    end
                end
                StReq: begin
                    if (mem_resp_i) begin
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        state_d    = (count_after < CW'(QUEUE_DEPTH)) ? StReq : StIdle;
                    end
                end
                StDrain: begin
                    if (mem_resp_i) begin
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Control and pointer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            fetch_pc_q  <= RESET_PC;
            squash_pc_q <= RESET_PC;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            squash_pc_q <= squash_pc_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
        end
    end

    // Queue storage: cleared on reset, written at the write pointer on enqueue.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else if (enq) begin
            instr_mem_q[wr_ptr_q] <= mem_rdata_i;
            pc_mem_q[wr_ptr_q]    <= fetch_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: a queue-based reference model compared against the
// DUT every cycle, plus directed scenarios with literal expectations.
module tb_fetch_queue;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam logic [31:0] RPC   = 32'h0000_0060;
    localparam logic [31:0] KEY   = 32'h5A00_0000;
`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          redirect_i;
    logic [31:0]   redirect_pc_i;
    logic [31:0]   mem_address_o;
    logic          mem_read_o;
    logic [31:0]   mem_rdata_i;
    logic          mem_resp_i;
    logic          instr_valid_o;
    logic          instr_ready_i;
    logic [31:0]   instr_o;
    logic [31:0]   instr_pc_o;
    logic [CW-1:0] count_o;

    always #5 clk = ~clk;

    fetch_queue #(
        .QUEUE_DEPTH (DEPTH),
        .RESET_PC    (RPC)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_address_o (mem_address_o),
        .mem_read_o    (mem_read_o),
        .mem_rdata_i   (mem_rdata_i),
        .mem_resp_i    (mem_resp_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .count_o       (count_o)
    );

    int checks_total  = 0;
    int checks_passed = 0;
    bit check_en      = 1'b0;

    // Reference model: buffered {instr, pc} entries, fetch PC, outstanding read info.
    logic [63:0] mq [$];
    bit          m_out;
    bit          m_keep;
    logic [31:0] m_fpc;
    logic [31:0] m_raddr;

    // Memory: responds once a read has been up for mem_lat cycles; data = addr ^ KEY.
    int mem_lat  = 1;
    int mem_wait = 0;

    logic [31:0] delivered [$];
    logic [31:0] issued    [$];
    int          max_count;
    logic        last_valid;
    logic        last_resp;
    logic [31:0] last_pc;
    logic [31:0] last_count;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks_total++;
        if (act === exp) checks_passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // One clock cycle: drive memory, compare at the falling edge, advance model at rising.
    task automatic step();
        bit          byp;
        bit          m_valid;
        bit          deq;
        int          osz;
        logic [63:0] head;
        mem_resp_i  = mem_read_o && (mem_wait + 1 >= mem_lat);
        mem_rdata_i = mem_resp_i ? (mem_address_o ^ KEY) : 32'h0;
        @(negedge clk);
        byp     = BYP && m_out && m_keep && mem_resp_i && !redirect_i && (mq.size() == 0);
        m_valid = ((mq.size() != 0) || byp) && !redirect_i;
        if (check_en) begin
            check32("mem_read_o", {31'b0, mem_read_o}, {31'b0, m_out});
            check32("mem_address_o", mem_address_o, (m_out && !m_keep) ? m_raddr : m_fpc);
            check32("count_o", 32'(count_o), mq.size());
            check32("instr_valid_o", {31'b0, instr_valid_o}, {31'b0, m_valid});
            if (m_valid) begin
                head = byp ? {mem_rdata_i, m_fpc} : mq[0];
                check32("instr_o", instr_o, head[63:32]);
                check32("instr_pc_o", instr_pc_o, head[31:0]);
            end
        end
        last_valid = instr_valid_o;
        last_resp  = mem_resp_i;
        last_pc    = instr_pc_o;
        last_count = 32'(count_o);
        if (instr_valid_o && instr_ready_i) delivered.push_back(instr_pc_o);
        if (mem_read_o && mem_resp_i) issued.push_back(mem_address_o);
        if (int'(count_o) > max_count) max_count = int'(count_o);
        if (!mem_read_o || mem_resp_i) mem_wait = 0;
        else mem_wait++;

        osz = mq.size();
        deq = (osz != 0) && !redirect_i && instr_ready_i;
        if (rst) begin
            mq.delete();
            m_out  = 1'b0;
            m_keep = 1'b0;
            m_fpc  = RPC;
        end else if (redirect_i) begin
            mq.delete();
            if (m_out && !mem_resp_i) begin
                if (m_keep) m_raddr = m_fpc;
                m_keep = 1'b0;
            end else begin
                m_out = 1'b0;
            end
            m_fpc = redirect_pc_i;
        end else begin
            if (deq) void'(mq.pop_front());
            if (m_out && mem_resp_i) begin
                if (m_keep) begin
                    if (!(byp && instr_ready_i)) mq.push_back({mem_rdata_i, m_fpc});
                    m_fpc = m_fpc + 32'd4;
                    m_out = (mq.size() < DEPTH);
                end else begin
                    m_out = 1'b0;
                end
                m_keep = 1'b1;
            end else if (!m_out && (osz < DEPTH)) begin
                m_out  = 1'b1;
                m_keep = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check_en = 1'b1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        redirect_i = 1'b0;
        step();
        rst        = 1'b0;
    endtask

    // Squash a pending read to 0x6C, optionally re-redirect while draining.
    task automatic drain_case(input bit second, input logic [31:0] exp_pc);
        bit found;
        int hits;
        do_reset();
        mem_lat       = 4;
        instr_ready_i = 1'b1;
        found         = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (mem_read_o && mem_address_o == 32'h6C && mem_wait == 1) found = 1'b1;
            else step();
        end
        check32("drain_found_read_6c", {31'b0, found}, 32'd1);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h400;
        step();
        if (second) begin
            redirect_pc_i = 32'h440;
            step();
        end
        redirect_i = 1'b0;
        check32("drain_addr_held", mem_address_o, 32'h6C);
        check32("drain_read_held", {31'b0, mem_read_o}, 32'd1);
        delivered.delete();
        issued.delete();
        repeat (20) step();
        check32("drain_squashed_resp_addr", issued[0], 32'h6C);
        check32("drain_next_read", issued[1], exp_pc);
        check32("drain_first_delivered", delivered[0], exp_pc);
        hits = 0;
        foreach (delivered[i]) if (delivered[i] == 32'h6C) hits++;
        check32("drain_6c_never_delivered", hits, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst           = 1'b1;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        instr_ready_i = 1'b0;
        mem_resp_i    = 1'b0;
        mem_rdata_i   = 32'h0;
        m_out         = 1'b0;
        m_keep        = 1'b0;
        m_fpc         = RPC;
        m_raddr       = 32'h0;
        max_count     = 0;
        #1;

        // Reset values.
        repeat (2) step();
        check32("reset_instr_o", instr_o, 32'h0);
        check32("reset_instr_pc_o", instr_pc_o, 32'h0);
        check32("reset_addr", mem_address_o, RPC);
        check32("reset_read", {31'b0, mem_read_o}, 32'd0);

        // Streaming with 1-cycle memory, decoder always ready.
        rst           = 1'b0;
        instr_ready_i = 1'b1;
        mem_lat       = 1;
        delivered.delete();
        max_count     = 0;
        repeat (12) step();
        check32("stream_pc0", delivered[0], 32'h60);
        check32("stream_pc1", delivered[1], 32'h64);
        check32("stream_pc2", delivered[2], 32'h68);
        check32("stream_throughput", delivered.size(), 10);
        check32("stream_max_count", max_count, 1);

        // Fill with decoder stalled, then release.
        do_reset();
        instr_ready_i = 1'b0;
        issued.delete();
        repeat (8) step();
        check32("fill_reads", issued.size(), 4);
        check32("fill_last_read", issued[3], 32'h6C);
        check32("fill_read_low", {31'b0, mem_read_o}, 32'd0);
        check32("fill_count", 32'(count_o), 32'd4);
        instr_ready_i = 1'b1;
        repeat (4) step();
        check32("refill_read", issued[4], 32'h70);

        // Redirect with three entries buffered and no read outstanding.
        do_reset();
        instr_ready_i = 1'b0;
        repeat (8) step();
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        check32("redir_pre_count", 32'(count_o), 32'd3);
        check32("redir_pre_read", {31'b0, mem_read_o}, 32'd0);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        step();
        redirect_i    = 1'b0;
        check32("redir_count", 32'(count_o), 32'd0);
        check32("redir_addr", mem_address_o, 32'h200);
        delivered.delete();
        instr_ready_i = 1'b1;
        repeat (5) step();
        check32("redir_first_pc", delivered[0], 32'h200);

        // Redirect while a slow read is pending, single and double.
        drain_case(1'b0, 32'h400);
        drain_case(1'b1, 32'h440);

        // PC wraps modulo 2^32.
        do_reset();
        mem_lat       = 1;
        instr_ready_i = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        step();
        redirect_i = 1'b0;
        delivered.delete();
        repeat (6) step();
        check32("wrap_pc0", delivered[0], 32'hFFFF_FFFC);
        check32("wrap_pc1", delivered[1], 32'h0000_0000);

        // Reset in the middle of a request.
        mem_lat = 4;
        repeat (2) step();
        check32("midrst_pre_read", {31'b0, mem_read_o}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check32("midrst_read", {31'b0, mem_read_o}, 32'd0);
        check32("midrst_count", 32'(count_o), 32'd0);
        check32("midrst_addr", mem_address_o, RPC);
        check32("midrst_valid", {31'b0, instr_valid_o}, 32'd0);

        // Empty queue, response for 0x80 with decoder ready.
        do_reset();
        mem_lat       = 1;
        instr_ready_i = 1'b1;
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h80;
        step();
        redirect_i = 1'b0;
        step();
        step();
        check32("bypass_resp_cycle", {31'b0, last_resp}, 32'd1);
        check32("bypass_valid", {31'b0, last_valid}, {31'b0, BYP});
        if (BYP) check32("bypass_pc", last_pc, 32'h80);
        check32("bypass_count_in_cycle", last_count, 32'd0);
        check32("bypass_count_after", 32'(count_o), BYP ? 32'd0 : 32'd1);
        repeat (4) step();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
